// File: rtl/s4_cond_pkg.sv
// s4_cond_pkg: shared types for the condition unit.
// Flag bundle, ARM-style condition codes, FSM states.
package s4_cond_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC,
    MI, PL, VS, VC,
    HI, LS, GE, LT,
    GT, LE, AL, NV
  } cond_e;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

endpackage

// File: rtl/s4_cond_eval.sv
// s4_cond_eval: combinational condition-code evaluator.
// Ports: i_cond (cond_e), i_flags (flags_t) -> o_taken.
module s4_cond_eval
  import s4_cond_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_taken
);

  logic w_nv_eq;

  assign w_nv_eq = (i_flags.n == i_flags.v);

  always_comb begin
    o_taken = 1'b0;
    unique case (i_cond)
      EQ: o_taken = i_flags.z;
      NE: o_taken = !i_flags.z;
      CS: o_taken = i_flags.c;
      CC: o_taken = !i_flags.c;
      MI: o_taken = i_flags.n;
      PL: o_taken = !i_flags.n;
      VS: o_taken = i_flags.v;
      VC: o_taken = !i_flags.v;
      HI: o_taken = i_flags.c && !i_flags.z;
      LS: o_taken = !i_flags.c || i_flags.z;
      GE: o_taken = w_nv_eq;
      LT: o_taken = !w_nv_eq;
      GT: o_taken = !i_flags.z && w_nv_eq;
      LE: o_taken = i_flags.z || !w_nv_eq;
      AL: o_taken = 1'b1;
      NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/s4_cond_unit.sv
// s4_cond_unit: NZCV flag register + condition query
// unit with a single-entry valid/ready response buffer.
// Ports: clk, reset (async, active-high); flag_we,
//   N_in/Z_in/C_in/V_in; req_valid/req_ready/cond;
//   resp_valid/resp_ready/resp_taken; flags_q {N,Z,C,V};
//   taken_cnt/nottaken_cnt (CNT_W).
// Macro S4_COND_STATS_EN enables saturating response
// counters; otherwise the counter ports read 0.
module s4_cond_unit
  import s4_cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic             N_in,
  input  logic             Z_in,
  input  logic             C_in,
  input  logic             V_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       cond,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  state_e r_state;
  state_e w_state_nx;
  flags_t r_flags;
  flags_t w_flags_nx;
  logic   r_taken;
  logic   w_taken;
  logic   w_accept;
  logic   w_hs;

  // Write-before-read: a query in a flag_we cycle
  // sees the incoming flags.
  assign w_flags_nx = flag_we ?
    flags_t'({N_in, Z_in, C_in, V_in}) : r_flags;

  assign w_accept = req_valid && req_ready;
  assign w_hs     = resp_valid && resp_ready;

  s4_cond_eval u_eval (
    .i_cond  (cond_e'(cond)),
    .i_flags (w_flags_nx),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nx = RESP;
      RESP: if (resp_ready)
              w_state_nx = req_valid ? RESP : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (r_state == RESP);
    req_ready  = (r_state == IDLE) || resp_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_flags <= '0;
    else if (flag_we) r_flags <= w_flags_nx;
  end

  // Only loads on accept, so a stalled response
  // holds even if the flags change underneath it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_taken <= 1'b0;
    else if (w_accept) r_taken <= w_taken;
  end

  assign flags_q    = r_flags;
  assign resp_taken = r_taken;

`ifdef S4_COND_STATS_EN
  logic [CNT_W-1:0] r_tk_cnt;
  logic [CNT_W-1:0] r_nt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tk_cnt <= '0;
      r_nt_cnt <= '0;
    end else if (w_hs) begin
      if (r_taken) begin
        if (~&r_tk_cnt) r_tk_cnt <= r_tk_cnt + 1'b1;
      end else begin
        if (~&r_nt_cnt) r_nt_cnt <= r_nt_cnt + 1'b1;
      end
    end
  end

  assign taken_cnt    = r_tk_cnt;
  assign nottaken_cnt = r_nt_cnt;
`else
  logic w_unused;
  assign w_unused     = w_hs;
  assign taken_cnt    = '0;
  assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_s4_cond_unit.sv
// tb_s4_cond_unit: directed bench with a scoreboard
// queue of expected resp_taken values.
module tb_s4_cond_unit;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         flag_we;
  logic [3:0]   nzcv;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   cond;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_taken;
  logic [3:0]   flags_q;
  logic [W-1:0] taken_cnt;
  logic [W-1:0] nottaken_cnt;

  int n_vec = 0;
  int n_bad = 0;

  bit         q[$];
  bit         m_busy = 0;
  logic [3:0] m_flags = 4'h0;
  int         m_tk = 0;
  int         m_nt = 0;

  s4_cond_unit #(.CNT_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flag_we      (flag_we),
    .N_in         (nzcv[3]),
    .Z_in         (nzcv[2]),
    .C_in         (nzcv[1]),
    .V_in         (nzcv[0]),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .cond         (cond),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_taken   (resp_taken),
    .flags_q      (flags_q),
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
  );

  always #5 clk = ~clk;

  // ARM scheme: cond[3:1] picks a base test,
  // cond[0] inverts it (AL/NV fall out naturally).
  function automatic bit model(input logic [3:0] c,
                               input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int m);
`ifdef S4_COND_STATS_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  task automatic drive(input bit we,
                       input logic [3:0] f,
                       input bit rv,
                       input logic [3:0] c,
                       input bit rr);
    flag_we    = we;
    nzcv       = f;
    req_valid  = rv;
    cond       = c;
    resp_ready = rr;
  endtask

  task automatic tick();
    bit acc, hs, t;
    logic [3:0] fn;
    @(negedge clk);
    chk("req_ready", req_ready, !m_busy || resp_ready);
    chk("resp_valid", resp_valid, m_busy);
    chk("flags_q", flags_q, m_flags);
    chk("taken_cnt", taken_cnt, exp_cnt(m_tk));
    chk("nottaken_cnt", nottaken_cnt, exp_cnt(m_nt));
    if (m_busy)
      chk("resp_taken", resp_taken, q[0]);
    acc = req_valid && (!m_busy || resp_ready);
    hs  = m_busy && resp_ready;
    fn  = flag_we ? nzcv : m_flags;
    if (hs) begin
      t = q.pop_front();
      if (t) begin if (m_tk != 3) m_tk++; end
      else   begin if (m_nt != 3) m_nt++; end
    end
    if (acc) q.push_back(model(cond, fn));
    m_busy = acc || (m_busy && !resp_ready);
    if (flag_we) m_flags = fn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 4'h0, 0, 4'h0, 1);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_taken", resp_taken, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_tk", taken_cnt, 0);
    chk("rst_nt", nottaken_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 0x8F+0xAD -> N0 Z0 C1 V1
    drive(1, 4'b0011, 0, 4'h0, 1); tick();
    drive(0, 4'b0000, 1, 4'hC, 1); tick();
    drive(0, 4'b0000, 1, 4'h2, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();
    chk("flags_0011", flags_q, 4'b0011);

    // 0xFF+0x01 -> N0 Z1 C1 V0, bypass EQ
    drive(1, 4'b0110, 1, 4'h0, 1); tick();
    drive(0, 4'b0000, 1, 4'h9, 1); tick();
    drive(0, 4'b0000, 1, 4'h8, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();

    // 100+89 -> N1 Z0 C0 V1, back-to-back
    drive(1, 4'b1001, 1, 4'hA, 1); tick();
    drive(0, 4'b0000, 1, 4'hB, 1); tick();
    drive(0, 4'b0000, 1, 4'h4, 1); tick();
    drive(0, 4'b0000, 1, 4'h6, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();

    // Stall 3 cycles with flags changing
    drive(0, 4'b0000, 1, 4'hD, 1); tick();
    drive(1, 4'b0100, 1, 4'hF, 0); tick();
    drive(1, 4'b1010, 1, 4'hF, 0); tick();
    drive(1, 4'b0001, 1, 4'hF, 0); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();

    // AL x5 and NV to exercise saturation
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b0000, 1, 4'hE, 1); tick();
    end
    drive(0, 4'b0000, 1, 4'hF, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();

    // Reset while a response is pending
    drive(1, 4'b1111, 1, 4'h0, 0); tick();
    drive(0, 4'b0000, 0, 4'h0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_flags", flags_q, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_tk", taken_cnt, 0);
    chk("arst_nt", nottaken_cnt, 0);
    q.delete();
    m_busy  = 0;
    m_flags = 4'h0;
    m_tk    = 0;
    m_nt    = 0;
    tick();
    reset = 1'b0;
    drive(0, 4'b0000, 1, 4'h1, 1); tick();
    drive(0, 4'b0000, 0, 4'h0, 1); tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
